// File: rtl/load_align_unit_pkg.sv
// Shared load opcodes, access-size/extension decode and FSM state encodings
// for the MEM-stage load alignment unit.
package load_align_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWU = 6'h27;
  localparam logic [5:0] OP_LD  = 6'h37;

  // Access size encoded as log2(bytes).
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ0, ST_WAIT0, ST_REQ1, ST_WAIT1, ST_RESP
  } state_e;

  typedef struct packed {
    logic  legal;
    size_e size;
    logic  sext;
  } op_dec_t;

  // On a 32-bit bus lw fills the whole result, so it needs no sign fill,
  // and the doubleword-only opcodes are illegal.
  function automatic op_dec_t decode_op(input logic [5:0] op, input logic wide);
    op_dec_t d;
    d.legal = 1'b1;
    d.size  = SZ_B;
    d.sext  = 1'b0;
    case (op)
      OP_LB:   begin d.size = SZ_B; d.sext = 1'b1; end
      OP_LH:   begin d.size = SZ_H; d.sext = 1'b1; end
      OP_LW:   begin d.size = SZ_W; d.sext = wide; end
      OP_LBU:  d.size = SZ_B;
      OP_LHU:  d.size = SZ_H;
      OP_LWU:  begin d.size = SZ_W; d.legal = wide; end
      OP_LD:   begin d.size = SZ_D; d.sext = 1'b1; d.legal = wide; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Combinational byte-lane extractor: picks the addressed bytes out of the
// {beat1,beat0} pair and zero/sign-extends them to the bus width.
module load_lane_extract
  import load_align_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic [2*DATA_W-1:0] beats,
  input  logic [OFS_W-1:0]    offset,
  input  size_e               size,
  input  logic                sext,
  output logic [DATA_W-1:0]   result
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] shifted;
  logic [3:0]        nbytes;
  logic              fill;

  always_comb begin
    shifted = DATA_W'(beats >> {offset, 3'b000});
    nbytes  = 4'd1 << size;
    case (size)
      SZ_B:    fill = sext & shifted[7];
      SZ_H:    fill = sext & shifted[15];
      SZ_W:    fill = sext & shifted[31];
      default: fill = sext & shifted[DATA_W-1];
    endcase
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    localparam logic [3:0] LANE = 4'(gi);
    assign result[8*gi +: 8] = (LANE < nbytes) ? shifted[8*gi +: 8] : {8{fill}};
  end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load alignment unit: one or two bus reads, lane merge, extension.
// Define LOAD_MISALIGN_SPLIT_EN to service misaligned loads instead of raising AdEL.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  size_e             size_reg;
  logic              sext_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_err_reg;

  op_dec_t             dec;
  logic [3:0]          size_bytes;
  logic                req_err;
  logic [ADDR_W-1:0]   line_addr;
  logic [2*DATA_W-1:0] beats;
  logic [DATA_W-1:0]   extracted;

  assign dec        = decode_op(req_op, DATA_W == 64);
  assign size_bytes = 4'd1 << dec.size;
  assign line_addr  = {addr_reg[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

`ifdef LOAD_MISALIGN_SPLIT_EN
  logic [DATA_W-1:0] beat0_reg;
  logic              cross_reg;
  logic              req_cross;

  assign req_err   = !dec.legal;
  assign req_cross = (5'(req_addr[OFS_W-1:0]) + 5'(size_bytes)) > 5'(NB);
  // In WAIT0 beat0 is still on the bus; in WAIT1 the bus carries beat1.
  assign beats     = {mem_rdata, (state_reg == ST_WAIT0) ? mem_rdata : beat0_reg};
`else
  assign req_err   = !dec.legal ||
                     (({1'b0, req_addr[2:0]} & (size_bytes - 4'd1)) != 4'd0);
  assign beats     = {{DATA_W{1'b0}}, mem_rdata};
`endif

  load_lane_extract #(
    .DATA_W (DATA_W),
    .OFS_W  (OFS_W)
  ) u_extract (
    .beats  (beats),
    .offset (addr_reg[OFS_W-1:0]),
    .size   (size_reg),
    .sext   (sext_reg),
    .result (extracted)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_valid) state_next = req_err ? ST_RESP : ST_REQ0;
      ST_REQ0:  if (mem_gnt) state_next = ST_WAIT0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      ST_WAIT0: if (mem_rvalid) state_next = cross_reg ? ST_REQ1 : ST_RESP;
      ST_REQ1:  if (mem_gnt) state_next = ST_WAIT1;
      ST_WAIT1: if (mem_rvalid) state_next = ST_RESP;
`else
      ST_WAIT0: if (mem_rvalid) state_next = ST_RESP;
`endif
      ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    if (state_reg == ST_REQ0) begin
      mem_req  = 1'b1;
      mem_addr = line_addr;
    end
`ifdef LOAD_MISALIGN_SPLIT_EN
    if (state_reg == ST_REQ1) begin
      mem_req  = 1'b1;
      mem_addr = line_addr + ADDR_W'(NB);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg     <= '0;
      size_reg     <= SZ_B;
      sext_reg     <= 1'b0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      beat0_reg    <= '0;
      cross_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: if (req_valid) begin
          addr_reg     <= req_addr;
          size_reg     <= dec.size;
          sext_reg     <= dec.sext;
          rsp_data_reg <= '0;
          rsp_err_reg  <= req_err;
`ifdef LOAD_MISALIGN_SPLIT_EN
          cross_reg    <= req_cross;
`endif
        end
        ST_WAIT0: if (mem_rvalid) begin
`ifdef LOAD_MISALIGN_SPLIT_EN
          beat0_reg <= mem_rdata;
          if (!cross_reg) rsp_data_reg <= extracted;
`else
          rsp_data_reg <= extracted;
`endif
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        ST_WAIT1: if (mem_rvalid) rsp_data_reg <= extracted;
`endif
        default: ;
      endcase
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: a 32-bit and a 64-bit instance run the same
// directed loads against a byte-addressed memory model and a reference model.
module tb_load_align_unit;

`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [5:0]  req_op = '0;
  logic [31:0] req_addr = '0;

  logic        req_ready32, mreq32, gnt32, mrv32, rsp_valid32, rsp_err32;
  logic [31:0] maddr32, mrdata32, rsp_data32;
  logic        req_ready64, mreq64, gnt64, mrv64, rsp_valid64, rsp_err64;
  logic [31:0] maddr64;
  logic [63:0] mrdata64, rsp_data64;

  int          gnt_delay = 0;
  logic        rv_block = 1'b0;
  logic        inj_rv = 1'b0;
  int          gc32 = 0, gc64 = 0;
  logic        rvr32 = 1'b0, rvr64 = 1'b0;
  logic [31:0] rd32 = '0;
  logic [63:0] rd64 = '0;
  logic [31:0] ga32[$], ga64[$];

  logic [7:0]  mem [logic [31:0]];

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  logic [63:0] exp_d32 = '0, exp_d64 = '0;
  logic        exp_e32 = 1'b0, exp_e64 = 1'b0;
  logic        pmreq32 = 1'b0, pmreq64 = 1'b0;
  logic [31:0] pmaddr32 = '0, pmaddr64 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready32),
    .req_op(req_op), .req_addr(req_addr), .mem_req(mreq32), .mem_gnt(gnt32),
    .mem_addr(maddr32), .mem_rvalid(mrv32), .mem_rdata(mrdata32),
    .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready), .rsp_data(rsp_data32),
    .rsp_err(rsp_err32)
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready64),
    .req_op(req_op), .req_addr(req_addr), .mem_req(mreq64), .mem_gnt(gnt64),
    .mem_addr(maddr64), .mem_rvalid(mrv64), .mem_rdata(mrdata64),
    .rsp_valid(rsp_valid64), .rsp_ready(rsp_ready), .rsp_data(rsp_data64),
    .rsp_err(rsp_err64)
  );

  function automatic logic [7:0] rdb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [63:0] rdline(input logic [31:0] a, input int nb);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = rdb(a + k);
    return v;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input int nb);
    for (int k = 0; k < nb; k++) mem[a + k] = d[8*k +: 8];
  endtask

  // Memory: grant after gnt_delay waiting cycles, data one cycle after grant.
  assign gnt32    = mreq32 && (gc32 >= gnt_delay);
  assign gnt64    = mreq64 && (gc64 >= gnt_delay);
  assign mrv32    = rvr32 | inj_rv;
  assign mrv64    = rvr64 | inj_rv;
  assign mrdata32 = inj_rv ? 32'hDEAD_BEEF : rd32;
  assign mrdata64 = inj_rv ? 64'hDEAD_BEEF_DEAD_BEEF : rd64;

  always @(posedge clk) begin
    gc32  <= (mreq32 && !gnt32) ? gc32 + 1 : 0;
    gc64  <= (mreq64 && !gnt64) ? gc64 + 1 : 0;
    rvr32 <= gnt32 && !rv_block;
    rvr64 <= gnt64 && !rv_block;
    if (gnt32) begin
      rd32 <= 32'(rdline(maddr32, 4));
      ga32.push_back(maddr32);
    end
    if (gnt64) begin
      rd64 <= rdline(maddr64, 8);
      ga64.push_back(maddr64);
    end
  end

  // Reference: read the addressed bytes straight from memory and extend.
  function automatic void model(input int w, input logic [5:0] op, input logic [31:0] a,
                                output logic [63:0] d, output logic e, output int nr);
    int size, nb;
    bit sgn, legal;
    logic [63:0] v;
    size = 1; sgn = 1'b0; legal = 1'b1; nb = w / 8; v = '0;
    case (op)
      6'h20: begin size = 1; sgn = 1'b1; end
      6'h21: begin size = 2; sgn = 1'b1; end
      6'h23: begin size = 4; sgn = (w == 64); end
      6'h24: size = 1;
      6'h25: size = 2;
      6'h27: begin size = 4; legal = (w == 64); end
      6'h37: begin size = 8; sgn = 1'b1; legal = (w == 64); end
      default: legal = 1'b0;
    endcase
    d = '0; e = 1'b1; nr = 0;
    if (!legal) return;
    if ((a % size) != 0 && !SPLIT) return;
    for (int k = 0; k < size; k++) v[8*k +: 8] = rdb(a + k);
    if (sgn && v[8*size-1])
      for (int k = size; k < 8; k++) v[8*k +: 8] = 8'hFF;
    if (w == 32) v[63:32] = '0;
    d = v; e = 1'b0;
    nr = (int'(a % nb) + size > nb) ? 2 : 1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic pin(input string nm, input int w, input logic [5:0] op,
                     input logic [31:0] a, input logic [63:0] ed, input logic ee);
    logic [63:0] d;
    logic e;
    int nr;
    model(w, op, a, d, e, nr);
    check({nm, "_model_data"}, d, ed);
    check({nm, "_model_err"}, 64'(e), 64'(ee));
  endtask

  // Per-cycle output checks against the current expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid32) begin
        check("rsp32_data", {32'h0, rsp_data32}, exp_d32);
        check("rsp32_err", 64'(rsp_err32), 64'(exp_e32));
        check("rsp32_req_ready", 64'(req_ready32), 64'd0);
      end
      if (rsp_valid64) begin
        check("rsp64_data", rsp_data64, exp_d64);
        check("rsp64_err", 64'(rsp_err64), 64'(exp_e64));
        check("rsp64_req_ready", 64'(req_ready64), 64'd0);
      end
      if (mreq32) check("req32_ready_low", 64'(req_ready32), 64'd0);
      if (mreq64) check("req64_ready_low", 64'(req_ready64), 64'd0);
      if (mreq32 && pmreq32) check("addr32_hold", 64'(maddr32), 64'(pmaddr32));
      if (mreq64 && pmreq64) check("addr64_hold", 64'(maddr64), 64'(pmaddr64));
    end
    pmreq32  <= mreq32 && !gnt32;
    pmreq64  <= mreq64 && !gnt64;
    pmaddr32 <= maddr32;
    pmaddr64 <= maddr64;
  end

  function automatic int exp_lat(input logic e, input int nr, input int gdly);
    return e ? 1 : 1 + 2 * nr + gdly * nr;
  endfunction

  task automatic txn(input logic [5:0] op, input logic [31:0] a, input int gdly, input int hold);
    int nr32, nr64, acc, n;
    bit got32, got64;
    logic [31:0] line32, line64;
    model(32, op, a, exp_d32, exp_e32, nr32);
    model(64, op, a, exp_d64, exp_e64, nr64);
    line32 = a & ~32'h3;
    line64 = a & ~32'h7;
    gnt_delay = gdly;
    ga32.delete();
    ga64.delete();
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = a;
    @(negedge clk);
    check("accept32_ready", 64'(req_ready32), 64'd1);
    check("accept64_ready", 64'(req_ready64), 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got32 = 1'b0; got64 = 1'b0; n = 0;
    while (!(got32 && got64) && n < 100) begin
      @(negedge clk);
      n++;
      if (!got32 && rsp_valid32) begin
        got32 = 1'b1;
        check("lat32", 64'(cyc - acc), 64'(exp_lat(exp_e32, nr32, gdly)));
      end
      if (!got64 && rsp_valid64) begin
        got64 = 1'b1;
        check("lat64", 64'(cyc - acc), 64'(exp_lat(exp_e64, nr64, gdly)));
      end
    end
    if (!got32) begin
      n_cmp++; n_bad++;
      $display("FAIL resp32_timeout: no rsp_valid within %0d cycles, expected one", n);
    end
    if (!got64) begin
      n_cmp++; n_bad++;
      $display("FAIL resp64_timeout: no rsp_valid within %0d cycles, expected one", n);
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("drop32_valid", 64'(rsp_valid32), 64'd0);
    check("drop64_valid", 64'(rsp_valid64), 64'd0);
    check("idle32_ready", 64'(req_ready32), 64'd1);
    check("idle64_ready", 64'(req_ready64), 64'd1);
    check("reads32", 64'(ga32.size()), 64'(nr32));
    check("reads64", 64'(ga64.size()), 64'(nr64));
    if (nr32 >= 1 && ga32.size() >= 1) check("rd0_addr32", 64'(ga32[0]), 64'(line32));
    if (nr32 == 2 && ga32.size() == 2) check("rd1_addr32", 64'(ga32[1]), 64'(line32 + 32'd4));
    if (nr64 >= 1 && ga64.size() >= 1) check("rd0_addr64", 64'(ga64[0]), 64'(line64));
    if (nr64 == 2 && ga64.size() == 2) check("rd1_addr64", 64'(ga64[1]), 64'(line64 + 32'd8));
    $display("txn op=%h addr=%h | w32 data=%h err=%0d reads=%0d | w64 data=%h err=%0d reads=%0d",
             op, a, rsp_data32, rsp_err32, ga32.size(), rsp_data64, rsp_err64, ga64.size());
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst32_req_ready", 64'(req_ready32), 64'd1);
    check("rst32_mem_req", 64'(mreq32), 64'd0);
    check("rst32_mem_addr", 64'(maddr32), 64'd0);
    check("rst32_rsp_valid", 64'(rsp_valid32), 64'd0);
    check("rst32_rsp_data", 64'(rsp_data32), 64'd0);
    check("rst32_rsp_err", 64'(rsp_err32), 64'd0);
    check("rst64_req_ready", 64'(req_ready64), 64'd1);
    check("rst64_rsp_data", rsp_data64, 64'd0);

    // Aligned byte/half loads.
    wr(32'h1000, 64'h8081_7F01, 4);
    wr(32'h1004, 64'h0, 4);
    pin("lb_1000", 32, 6'h20, 32'h1000, 64'h0000_0001, 1'b0);
    pin("lb_1003", 32, 6'h20, 32'h1003, 64'hFFFF_FF80, 1'b0);
    pin("lbu_1003", 32, 6'h24, 32'h1003, 64'h0000_0080, 1'b0);
    pin("lh_1002", 32, 6'h21, 32'h1002, 64'hFFFF_8081, 1'b0);
    txn(6'h20, 32'h1000, 0, 0);
    txn(6'h20, 32'h1003, 0, 0);
    txn(6'h24, 32'h1003, 0, 0);
    txn(6'h21, 32'h1002, 0, 1);

    // Slow grant and stalled consumer.
    txn(6'h23, 32'h1000, 3, 4);

    // Misaligned halfword inside one word.
`ifdef LOAD_MISALIGN_SPLIT_EN
    pin("lh_1001", 32, 6'h21, 32'h1001, 64'hFFFF_817F, 1'b0);
`else
    pin("lh_1001", 32, 6'h21, 32'h1001, 64'h0, 1'b1);
`endif
    txn(6'h21, 32'h1001, 0, 0);

    // Reset while waiting for read data, then a stale rvalid.
    rv_block = 1'b1;
    gnt_delay = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 6'h24; req_addr = 32'h1003;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait0_32_busy", 64'(req_ready32), 64'd0);
    check("wait0_64_busy", 64'(req_ready64), 64'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    inj_rv = 1'b1;
    @(negedge clk);
    check("rst_w0_32_ready", 64'(req_ready32), 64'd1);
    check("rst_w0_64_ready", 64'(req_ready64), 64'd1);
    @(posedge clk); #1;
    inj_rv = 1'b0;
    rv_block = 1'b0;
    @(negedge clk);
    check("stale32_rsp_valid", 64'(rsp_valid32), 64'd0);
    check("stale64_rsp_valid", 64'(rsp_valid64), 64'd0);
    check("stale32_mem_req", 64'(mreq32), 64'd0);
    txn(6'h24, 32'h1003, 0, 0);

    // Word spanning two 32-bit beats.
    wr(32'h1000, 64'hAABB_CCDD, 4);
    wr(32'h1004, 64'h1122_3344, 4);
`ifdef LOAD_MISALIGN_SPLIT_EN
    pin("lw_1002", 32, 6'h23, 32'h1002, 64'h3344_AABB, 1'b0);
`else
    pin("lw_1002", 32, 6'h23, 32'h1002, 64'h0, 1'b1);
`endif
    txn(6'h23, 32'h1002, 0, 0);
    txn(6'h23, 32'h1002, 2, 2);

    // Doubleword and 64-bit-only opcodes.
    wr(32'h2000, 64'hF000_0000_0000_0001, 8);
    pin("ld_2000", 64, 6'h37, 32'h2000, 64'hF000_0000_0000_0001, 1'b0);
    pin("lwu_2004", 64, 6'h27, 32'h2004, 64'h0000_0000_F000_0000, 1'b0);
    pin("lw_2004", 64, 6'h23, 32'h2004, 64'hFFFF_FFFF_F000_0000, 1'b0);
    pin("lwu32_2004", 32, 6'h27, 32'h2004, 64'h0, 1'b1);
    pin("lw32_2004", 32, 6'h23, 32'h2004, 64'hF000_0000, 1'b0);
    txn(6'h37, 32'h2000, 0, 0);
    txn(6'h27, 32'h2004, 0, 0);
    txn(6'h23, 32'h2004, 0, 0);
    txn(6'h25, 32'h2006, 1, 0);

    // Illegal opcode.
    pin("illegal_22", 64, 6'h22, 32'h2000, 64'h0, 1'b1);
    txn(6'h22, 32'h2000, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
